facto_booth_multiplier: RTL and testbench

//  Sequential radix-4 Booth multiplier, the arithmetic stage directly downstream of FactoCore.

---
 rtl/facto_booth_multiplier.sv | 131 +++++++++++++
 tb/tb_facto_booth_multiplier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/facto_booth_multiplier.sv
// facto_booth_multiplier
//   Sequential radix-4 Booth multiplier. One Booth digit is retired per clock,
//   so a signed WIDTH x WIDTH product takes WIDTH/2 clocks after the start edge.
//
// Ports
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   op_start     : start request, sampled only in IDLE
//   op_clear     : synchronous clear, wins over everything except reset
//   multiplicand : operand A (two's complement), latched on start
//   multiplier   : operand B (two's complement), latched on start
//   result       : signed product A*B, non-zero only while op_done=1
//   op_done      : level, high in DONE
module facto_booth_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               op_done
);

  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH+1:0]     r_acc;    // upper accumulator with two guard bits
  logic [WIDTH-1:0]     r_b;      // multiplier, shifted right as digits retire
  logic                 r_bm1;    // bit just below the current digit (B[2i-1])
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_done;

  logic [WIDTH+1:0]     w_a1;
  logic [WIDTH+1:0]     w_a2;
  logic [WIDTH+1:0]     w_pp;
  logic [WIDTH+1:0]     w_sum;
  logic [2*WIDTH+1:0]   w_cat;
  logic [2*WIDTH+1:0]   w_shift;

  // Sign-extended +A and +2A; the two guard bits keep -2A exact for the most negative A.
  assign w_a1 = {{2{r_a[WIDTH-1]}}, r_a};
  assign w_a2 = {r_a[WIDTH-1], r_a, 1'b0};

  // Booth digit recoding of the triplet {B[2i+1], B[2i], B[2i-1]}.
  always_comb begin
    w_pp = '0;
    case ({r_b[1:0], r_bm1})
      3'b001, 3'b010: w_pp = w_a1;
      3'b011:         w_pp = w_a2;
      3'b100:         w_pp = -w_a2;
      3'b101, 3'b110: w_pp = -w_a1;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum   = r_acc + w_pp;
  assign w_cat   = {w_sum, r_b};
  assign w_shift = $signed(w_cat) >>> 2;

  // Control FSM and datapath registers; clear beats state logic, reset beats all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_bm1    <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (op_clear) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_a     <= multiplicand;
            r_b     <= multiplier;
            r_acc   <= '0;
            r_bm1   <= 1'b0;
            r_count <= '0;
            r_state <= S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_acc   <= w_shift[2*WIDTH+1:WIDTH];
          r_b     <= w_shift[WIDTH-1:0];
          r_bm1   <= r_b[1];
          r_count <= r_count + CW'(1);
          if (r_count == LAST_DIGIT) begin
            // After the last shift the full product sits in {acc, b}.
            r_result <= w_shift[2*WIDTH-1:0];
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_result <= '0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign result  = r_result;
  assign op_done = r_done;

endmodule

// File: tb/tb_facto_booth_multiplier.sv
module tb_facto_booth_multiplier;

  logic         clk;
  logic         reset_n;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic [127:0] result;
  logic         op_done;

  typedef struct {
    logic [127:0] prod;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  facto_booth_multiplier #(.WIDTH(64)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .op_start(op_start),
    .op_clear(op_clear),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .result(result),
    .op_done(op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on sign-extended operands.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    return sa * sb;
  endfunction

  // Monitor: pops on each rising op_done, checks product and latency; otherwise result must read 0.
  always @(negedge clk) begin
    exp_t e;
    if (op_done && !prev_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=no_done", result);
      end else begin
        e = sb_q.pop_front();
        chk("product", result, e.prod);
        chk("latency_cycle", 128'(cyc), 128'(e.cyc));
      end
    end else if (!op_done) begin
      chk("result_zero_when_not_done", result, 128'd0);
    end
    prev_done = op_done;
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
    exp_t e;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    e.prod = exp;
    e.cyc  = cyc + 33;   // start edge is cyc+1, done visible after 32 more edges
    sb_q.push_back(e);
    @(negedge clk);
    op_start     = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !op_done; i++) @(negedge clk);
    if (!op_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
      sb_q.delete();
    end
  endtask

  task automatic clear_op();
    @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("clear_done", 128'(op_done), 128'd0);
    chk("clear_result", result, 128'd0);
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
    issue(a, b, exp);
    wait_done();
    @(negedge clk);
    clear_op();
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = 64'd0;
    multiplier   = 64'd0;
    repeat (2) @(negedge clk);
    chk("reset_done", 128'(op_done), 128'd0);
    chk("reset_result", result, 128'd0);
    reset_n = 1'b1;

    // Idle for 50 cycles with no start.
    repeat (50) @(negedge clk);
    chk("idle_done", 128'(op_done), 128'd0);

    // Directed products.
    run(64'd3, 64'd5, 128'd15);
    run(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    run(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
    run(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 128'hC000_0000_0000_0000_8000_0000_0000_0000);

    // Clear mid-EXEC with a simultaneous start: clear wins, start dropped.
    issue(64'd9, 64'd9, 128'd81);
    repeat (8) @(negedge clk);
    sb_q.delete();
    op_clear = 1'b1;
    op_start = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    op_start = 1'b0;
    chk("abort_done", 128'(op_done), 128'd0);
    chk("abort_result", result, 128'd0);
    repeat (40) @(negedge clk);
    chk("dropped_start_done", 128'(op_done), 128'd0);
    run(64'd4, 64'd4, 128'd16);

    // Start pulsed mid-EXEC and in DONE with new operands is ignored.
    issue(64'd6, 64'd7, 128'd42);
    repeat (5) @(negedge clk);
    multiplicand = 64'd100;
    multiplier   = 64'd100;
    op_start     = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    wait_done();
    @(negedge clk);
    multiplicand = 64'd2;
    multiplier   = 64'd2;
    op_start     = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_hold_level", 128'(op_done), 128'd1);
    chk("done_hold_result", result, 128'd42);
    clear_op();

    // Asynchronous reset between edges, mid-EXEC and in DONE.
    issue(64'd11, 64'd13, 128'd143);
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_exec_done", 128'(op_done), 128'd0);
    chk("async_reset_exec_result", result, 128'd0);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_idle", 128'(op_done), 128'd0);
    run(64'd20, 64'd19, 128'd380);

    issue(64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE7);
    wait_done();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_done_done", 128'(op_done), 128'd0);
    chk("async_reset_done_result", result, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized products against the reference model.
    for (int n = 0; n < 16; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 4 == 1) ra = {32'hFFFF_FFFF, $urandom};
      if (n % 4 == 2) rb = 64'(signed'($urandom_range(200, 0)) - 100);
      run(ra, rb, ref_mul(ra, rb));
    end

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
